// File: rtl/reg_file.sv
// 32-entry MIPS general-purpose register file: two combinational read ports,
// one synchronous write port, r0 hardwired to zero, same-cycle write-to-read bypass.
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  output logic [WIDTH-1:0]  Data1,
  output logic [WIDTH-1:0]  Data2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             write_ok;

  // A write to r0 is dropped here so entry 0 never leaves its reset value.
  assign write_ok = RegWrite && (WriteReg != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_ok) begin
      mem[WriteReg] <= WriteData;
    end
  end

  // Reset forces zero; otherwise r0 reads zero, a matching write bypasses, else storage.
  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] val;
    val = '0;
    if (!rst_n || addr == '0) begin
      val = '0;
    end else if (RegWrite && WriteReg == addr) begin
      val = WriteData;
    end else begin
      val = mem[addr];
    end
    return val;
  endfunction

  always_comb begin
    Data1 = read_port(ReadReg1);
    Data2 = read_port(ReadReg2);
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry general-purpose register file for the MIPS datapath.
- Sits directly upstream of the ALU. Read ports feed the ALU operands Data1 and Data2. The write port is driven by writeback.
- Two asynchronous read ports and one synchronous write port.
- Register 0 is hardwired to zero, and a same-cycle write-to-read bypass is included.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- ReadReg1  input  ADDR_W  read address, port 1 (rs).
- ReadReg2  input  ADDR_W  read address, port 2 (rt).
- WriteReg  input  ADDR_W  write address (rd/rt from writeback).
- WriteData  input  WIDTH  data to write.
- RegWrite  input  1  write enable.
- Data1  output  WIDTH  read data, port 1; goes to ALU Data1.
- Data2  output  WIDTH  read data, port 2; goes to ALU Data2.

Behaviour:
- Storage: 2**ADDR_W words of WIDTH bits, holding registers 0 to 2**ADDR_W-1.
- Reset (rst_n low at a rising edge):
  - All entries are cleared to 0 on that edge.
  - Any write presented in the same cycle is discarded; reset has priority over RegWrite.
- Reset visibility: while rst_n is low, Data1 and Data2 are forced to 0 combinationally, regardless of addresses or bypass.
- Write:
  - On a rising edge with rst_n high and RegWrite high, mem[WriteReg] takes WriteData.
  - When WriteReg = 0 the write is ignored; entry 0 is never anything but 0.
- Read:
  - Combinational, with zero-cycle latency.
  - DataN = 0 if ReadRegN = 0.
  - Otherwise, DataN = WriteData if RegWrite is high, rst_n is high and WriteReg = ReadRegN (bypass).
  - Otherwise, DataN = mem[ReadRegN].
- Bypass: a value written at edge k is visible on the read ports during cycle k (before the edge) via bypass, and from storage after the edge. It never returns stale data.
- Both read ports may address the same register; both return identical data.
- With RegWrite low, storage is unchanged indefinitely.
- X-safety: with RegWrite low, the value of WriteReg/WriteData has no effect.
- No internal pipeline; outputs change only in response to input changes or clock edges.
- Reset mid-operation: a write in the reset cycle is lost, and all registers read 0 from the first cycle after rst_n returns high.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, assert rst_n=0 for 1 cycle with RegWrite=1 WriteReg=7 WriteData=0x11111111, release. Required: Data1 is 0 for ReadReg1=5 and for ReadReg1=7.
- Basic write/read: write 0x0000000A to r3 and 0x00000005 to r4 on consecutive edges; ReadReg1=3, ReadReg2=4. Required: Data1=0x0000000A, Data2=0x00000005.
- Zero register: RegWrite=1, WriteReg=0, WriteData=0xFFFFFFFF, clock. Required: ReadReg1=0 gives Data1=0, both during the write cycle (no bypass) and after it.
- Bypass: r8 holds 0x00000001; in one cycle set RegWrite=1, WriteReg=8, WriteData=0x12345678, ReadReg1=8, ReadReg2=8. Required: Data1=Data2=0x12345678 before the edge, and the same after the edge with RegWrite=0.
- Write disable: r9=0x00000042, then RegWrite=0, WriteReg=9, WriteData=0x0 for 3 cycles. Required: Data2 for ReadReg2=9 stays 0x00000042.
- Full sweep: write i*0x01010101 to r1 to r31, then read every index on both ports. Required: each returns its value and r0 returns 0; drive Data1/Data2 into the ALU with selector 1001 for r2,r3 and expect 0x05050505.
